stddev_iter: RTL

- Second-generation window standard-deviation unit.
- Consumes one pre-computed window pair per transaction: the ii window sum S and the sii (squared) window sum Q, for a window of N = (WINDOW_HEIGHT-1)*(WINDOW_WIDTH-1) points.
- Computes variance V = N*Q - S^2, clamps negative V to 0, applies a parametrised right shift, then returns either floor(sqrt(V')) from an exact iterative bit-serial integer square root, or V' itself when variance mode is selected.
- Sits between the window_sum instances and the classifier normalisation stage. It replaces the fixed-shift sqrt-LUT path and has a full valid/ready handshake on both sides.

---
 rtl/stddev_iter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stddev_iter.sv
// stddev_iter: window variance / standard deviation from (S, Q) window sums.
// V = N*Q - S^2, clamped at 0, shifted, then exact bit-serial floor(sqrt).
module stddev_iter #(
    parameter int W_SUM         = 29,
    parameter int W_SQSUM       = 29,
    parameter int WINDOW_HEIGHT = 25,
    parameter int WINDOW_WIDTH  = 25,
    parameter int VAR_SHIFT     = 0,
    parameter int W_OUT         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_SUM-1:0]   in_sum,
    input  logic [W_SQSUM-1:0] in_sqsum,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_OUT-1:0]   out_data,
    output logic               out_flag
);

    localparam int N     = (WINDOW_HEIGHT - 1) * (WINDOW_WIDTH - 1);
    localparam int W_VAR = 2 * W_SUM + ((2 * W_SUM) % 2);
    localparam int ITER  = W_VAR / 2;
    localparam int W_REM = ITER + 2;
    localparam int W_CNT = $clog2(ITER) + 1;

    localparam logic [W_VAR:0]   NN   = (W_VAR + 1)'(N);
    localparam logic [W_VAR-1:0] MAXO = {{(W_VAR - W_OUT){1'b0}}, {W_OUT{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MULT,
        S_DIFF,
        S_SQRT,
        S_OUT
    } state_t;

    state_t             r_state;
    logic [W_SUM-1:0]   r_s;
    logic [W_SQSUM-1:0] r_q;
    logic               r_mode;
    logic [W_VAR:0]     r_p1;
    logic [W_VAR:0]     r_p2;
    logic [W_VAR-1:0]   r_var;
    logic [W_VAR-1:0]   r_rad;
    logic [W_REM-1:0]   r_rem;
    logic [ITER-1:0]    r_root;
    logic [W_CNT-1:0]   r_cnt;
    logic               r_flag;
    logic               r_out_valid;
    logic [W_OUT-1:0]   r_out_data;
    logic               r_out_flag;

    logic [W_VAR:0]     w_d;
    logic               w_neg;
    logic [W_VAR-1:0]   w_shift;
    logic [W_REM+1:0]   w_rem_t;
    logic [W_REM+1:0]   w_trial;
    logic               w_ge;
    logic [W_REM-1:0]   w_rem_n;
    logic [W_VAR-1:0]   w_res;
    logic               w_sat;

    // The sign bit of the widened difference is the clamp condition.
    assign w_d     = r_p1 - r_p2;
    assign w_neg   = w_d[W_VAR];
    assign w_shift = w_d[W_VAR-1:0] >> VAR_SHIFT;

    // One restoring step: bring down the next radicand pair, try 4*root+1.
    assign w_rem_t = {r_rem, r_rad[W_VAR-1 -: 2]};
    assign w_trial = {2'b00, r_root, 2'b01};
    assign w_ge    = (w_rem_t >= w_trial);
    assign w_rem_n = W_REM'(w_ge ? (w_rem_t - w_trial) : w_rem_t);

    assign w_res = r_mode ? r_var : W_VAR'(r_root);
    assign w_sat = (w_res > MAXO);

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_flag  = r_out_flag;

    // Transaction FSM: accept, multiply, subtract/clamp, sqrt, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_s         <= '0;
            r_q         <= '0;
            r_mode      <= 1'b0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_var       <= '0;
            r_rad       <= '0;
            r_rem       <= '0;
            r_root      <= '0;
            r_cnt       <= '0;
            r_flag      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_flag  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_s     <= in_sum;
                        r_q     <= in_sqsum;
                        r_mode  <= in_mode;
                        r_flag  <= 1'b0;
                        r_state <= S_MULT;
                    end
                end
                S_MULT: begin
                    r_p1    <= NN * (W_VAR + 1)'(r_q);
                    r_p2    <= (W_VAR + 1)'(r_s) * (W_VAR + 1)'(r_s);
                    r_state <= S_DIFF;
                end
                S_DIFF: begin
                    if (w_neg) begin
                        r_var  <= '0;
                        r_rad  <= '0;
                        r_flag <= 1'b1;
                    end else begin
                        r_var  <= w_shift;
                        r_rad  <= w_shift;
                    end
                    r_rem   <= '0;
                    r_root  <= '0;
                    r_cnt   <= W_CNT'(ITER - 1);
                    r_state <= r_mode ? S_OUT : S_SQRT;
                end
                S_SQRT: begin
                    r_rem  <= w_rem_n;
                    r_root <= {r_root[ITER-2:0], w_ge};
                    r_rad  <= {r_rad[W_VAR-3:0], 2'b00};
                    if (r_cnt == '0) begin
                        r_state <= S_OUT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_sat ? {W_OUT{1'b1}} : w_res[W_OUT-1:0];
                        r_out_flag  <= r_flag | w_sat;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
